// File: rtl/sha256_sched_pkg.sv
// Shared types for the SHA-256 job scheduler.
//   sched_state_t : sequencer states
//   sched_job_t   : one queued hash job {requester id, message addr, output addr}
//   ADDR_W        : address width of both job addresses
//   ID_W          : stored requester id width (wide enough for up to 8 requesters)
package sha256_sched_pkg;

  localparam int ADDR_W = 16;
  localparam int ID_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_DONE,
    REPORT
  } sched_state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] msg_addr;
    logic [ADDR_W-1:0] out_addr;
  } sched_job_t;

endpackage

// File: rtl/sha256_job_fifo.sv
// Small synchronous FIFO holding accepted hash jobs.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full)
//   pop, pop_data   : read the head entry (pop_data is the head, valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..DEPTH
module sha256_job_fifo
  import sha256_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = sched_job_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one simplified_sha256 core among N requesters.
// Requests are granted round-robin into a job FIFO; a sequencer issues one
// job at a time to the core and reports each completion (or watchdog timeout).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_valid[N], req_ready[N]   : per-requester handshake, ready is one-hot
//   req_msg_addr, req_out_addr   : per-requester addresses, 16 bits each, packed
//   core_start                   : one-cycle start pulse to the core
//   core_message_addr/output_addr: job addresses, stable for the whole job
//   core_done                    : core done level
//   cmp_valid, cmp_id, cmp_timeout : one-cycle completion report
//   err                          : sticky watchdog flag
//   busy                         : sequencer active or jobs queued
// Handshake: a job transfers on any cycle where req_valid[i] & req_ready[i];
// req_ready is a combinational grant and never depends on a same-cycle pop.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*ADDR_W-1:0]   req_msg_addr,
  input  logic [N*ADDR_W-1:0]   req_out_addr,
  output logic                  core_start,
  output logic [ADDR_W-1:0]     core_message_addr,
  output logic [ADDR_W-1:0]     core_output_addr,
  input  logic                  core_done,
  output logic                  cmp_valid,
  output logic [$clog2(N)-1:0]  cmp_id,
  output logic                  cmp_timeout,
  output logic                  err,
  output logic                  busy
);

  localparam int IDW = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  // ---------------- arbiter ----------------
  logic [IDW-1:0]           rr_ptr;
  logic [N-1:0]             grant;
  logic [IDW-1:0]           grant_idx;
  logic                     push;
  sched_job_t               push_job;
  sched_job_t               pop_job;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     pop;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    push      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % N;
      if (!push && !fifo_full && req_valid[idx]) begin
        push       = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    push_job          = '0;
    push_job.id       = ID_W'(grant_idx);
    push_job.msg_addr = req_msg_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    push_job.out_addr = req_out_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= IDW'(N-1);
    else if (push) rr_ptr <= grant_idx;
  end

  sha256_job_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (sched_job_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .pop_data  (pop_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- sequencer ----------------
  sched_state_t    state_q;
  sched_state_t    state_d;
  sched_job_t      job_q;
  logic [WDW-1:0]  wdog_q;
  logic [WDW-1:0]  wdog_inc;
  logic            wd_hit;
  logic            hit_to;
  logic            to_q;
  logic            err_q;

  // Saturating increment; the timeout fires on the edge where the count
  // reaches TIMEOUT-1.
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
  assign wd_hit   = (wdog_inc >= WDW'(TIMEOUT-1));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    hit_to  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_CLR;
      // Wait for the previous job's done level to drop before trusting done.
      WAIT_CLR: begin
        if (wd_hit) begin
          hit_to  = 1'b1;
          state_d = REPORT;
        end else if (!core_done) begin
          state_d = WAIT_DONE;
        end
      end
      // A done seen on the last watchdog cycle still counts as a normal finish.
      WAIT_DONE: begin
        if (core_done) begin
          state_d = REPORT;
        end else if (wd_hit) begin
          hit_to  = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      job_q   <= '0;
      wdog_q  <= '0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) job_q <= pop_job;
      if (state_q == ISSUE) begin
        wdog_q <= '0;
      end else if (state_q == WAIT_CLR || state_q == WAIT_DONE) begin
        wdog_q <= wdog_inc;
      end
      if (state_d == REPORT) to_q <= hit_to;
      if (hit_to) err_q <= 1'b1;
    end
  end

  assign core_start        = (state_q == ISSUE);
  assign core_message_addr = job_q.msg_addr;
  assign core_output_addr  = job_q.out_addr;
  assign cmp_valid         = (state_q == REPORT);
  assign cmp_id            = cmp_valid ? IDW'(job_q.id) : '0;
  assign cmp_timeout       = cmp_valid && to_q;
  assign err               = err_q;
  assign busy              = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: directed phases, a job-level reference model
// checked every cycle, and literal timing/ordering pins per phase.
module tb_sha256_job_scheduler;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*16-1:0]   req_msg_addr;
  logic [N*16-1:0]   req_out_addr;
  logic              core_start;
  logic [15:0]       core_message_addr;
  logic [15:0]       core_output_addr;
  logic              core_done;
  logic              cmp_valid;
  logic [1:0]        cmp_id;
  logic              cmp_timeout;
  logic              err;
  logic              busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  sha256_job_scheduler #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TO)) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_msg_addr      (req_msg_addr),
    .req_out_addr      (req_out_addr),
    .core_start        (core_start),
    .core_message_addr (core_message_addr),
    .core_output_addr  (core_output_addr),
    .core_done         (core_done),
    .cmp_valid         (cmp_valid),
    .cmp_id            (cmp_id),
    .cmp_timeout       (cmp_timeout),
    .err               (err),
    .busy              (busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- core model ----------------
  // After a start the core drops done clr_lag cycles later and raises it
  // done_delay cycles after start (never when done_delay is 0). Done stays
  // high until the next start.
  int core_start_c = 0;
  bit core_act     = 0;
  int done_delay   = 5;
  int clr_lag      = 1;

  always @(negedge clk) if (reset_n && core_start) begin
    core_start_c = cyc;
    core_act     = 1;
  end

  always @(posedge clk) begin
    #1;
    if (reset_n && core_act) begin
      if (cyc == core_start_c + clr_lag) core_done = 1'b0;
      if (done_delay > 0 && cyc == core_start_c + done_delay) core_done = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] msg;
    logic [15:0] out;
  } mjob_t;

  mjob_t       mq[$];
  mjob_t       cur;
  int          rr_m = N-1;
  bit          inf, seen_low, rep_set, rep_to, err_m;
  int          start_m, rep_m;
  logic [15:0] msg_m, out_m;

  // event logs from the DUT for the literal pins
  int          grant_log[$];
  int          start_log[$];
  logic [15:0] start_msg_log[$];
  logic [15:0] start_out_log[$];
  logic        done_at_start_log[$];
  int          cmp_log[$];
  int          cmp_id_log[$];
  logic        cmp_to_log[$];

  task automatic clear_logs();
    grant_log.delete(); start_log.delete(); start_msg_log.delete();
    start_out_log.delete(); done_at_start_log.delete();
    cmp_log.delete(); cmp_id_log.delete(); cmp_to_log.delete();
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           g;
    bit           pop_now;
    if (!reset_n) begin
      check("rst_core_start", core_start, 0);
      check("rst_msg_addr", core_message_addr, 0);
      check("rst_out_addr", core_output_addr, 0);
      check("rst_cmp_valid", cmp_valid, 0);
      check("rst_cmp_id", cmp_id, 0);
      check("rst_cmp_timeout", cmp_timeout, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_fifo_count", u_dut.u_fifo.count, 0);
      mq.delete();
      inf = 0; rep_set = 0; err_m = 0; rr_m = N-1; msg_m = '0; out_m = '0;
    end else begin
      // expected grant: first valid after the last winner, none when the queue is full
      exp_ready = '0;
      g = -1;
      if (mq.size() < DEPTH) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (rr_m + k) % N;
          if (g < 0 && req_valid[idx]) begin
            exp_ready[idx] = 1'b1;
            g = idx;
          end
        end
      end
      check("req_ready", req_ready, exp_ready);
      check("core_start", core_start, inf && cyc == start_m);
      check("cmp_valid", cmp_valid, inf && rep_set && cyc == rep_m);
      if (inf && rep_set && cyc == rep_m) begin
        check("cmp_id", cmp_id, cur.id);
        check("cmp_timeout", cmp_timeout, rep_to);
      end
      check("core_message_addr", core_message_addr, msg_m);
      check("core_output_addr", core_output_addr, out_m);
      check("err", err, err_m);
      check("busy", busy, inf || mq.size() > 0);
      check("fifo_count", u_dut.u_fifo.count, mq.size());

      // event logs (actual DUT behaviour)
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (core_start) begin
        start_log.push_back(cyc);
        start_msg_log.push_back(core_message_addr);
        start_out_log.push_back(core_output_addr);
        done_at_start_log.push_back(core_done);
      end
      if (cmp_valid) begin
        cmp_log.push_back(cyc);
        cmp_id_log.push_back(int'(cmp_id));
        cmp_to_log.push_back(cmp_timeout);
      end

      // advance the model past this clock edge
      pop_now = !inf && mq.size() > 0;
      if (inf) begin
        if (rep_set && cyc == rep_m) begin
          inf = 0;
        end else if (!rep_set && cyc > start_m) begin
          if (!seen_low) begin
            if (core_done == 1'b0) seen_low = 1;
          end else if (core_done == 1'b1) begin
            rep_set = 1; rep_m = cyc + 1; rep_to = 0;
          end
          if (!rep_set && cyc == start_m + TO - 1) begin
            rep_set = 1; rep_m = cyc + 1; rep_to = 1; err_m = 1;
          end
        end
      end
      if (pop_now) begin
        cur = mq.pop_front();
        msg_m = cur.msg; out_m = cur.out;
        inf = 1; start_m = cyc + 1; seen_low = 0; rep_set = 0; rep_to = 0;
      end
      if (g >= 0) begin
        mq.push_back({2'(g), req_msg_addr[g*16 +: 16], req_out_addr[g*16 +: 16]});
        rr_m = g;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    req_valid = '0;
    core_done = 1'b0;
    core_act  = 0;
    tick(n);
    reset_n = 1'b1;
  endtask

  // Raise valid for one requester until it transfers; returns the transfer cycle.
  task automatic submit(input int id, input logic [15:0] msg, input logic [15:0] out,
                        output int tcyc);
    req_msg_addr[id*16 +: 16] = msg;
    req_out_addr[id*16 +: 16] = out;
    req_valid[id] = 1'b1;
    tcyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        tcyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (tcyc < 0) check("submit_budget", 0, 1);
  endtask

  task automatic wait_cmp(input int budget, output int c);
    c = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cmp_valid) begin
        c = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (c < 0) check("cmp_budget", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) check("idle_budget", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, r1, r2;
    bit ok;
    reset_n      = 1'b0;
    req_valid    = '0;
    req_msg_addr = '0;
    req_out_addr = '0;
    core_done    = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // single job: requester 2, done 12 cycles after start
    clear_logs();
    done_delay = 12; clr_lag = 1;
    submit(2, 16'h0000, 16'h0100, t);
    wait_cmp(100, r1);
    check("single_start_lat", start_log[0] - t, 2);
    check("single_msg", start_msg_log[0], 16'h0000);
    check("single_out", start_out_log[0], 16'h0100);
    check("single_cmp_lat", r1 - start_log[0], 13);
    check("single_cmp_id", cmp_id_log[0], 2);
    check("single_cmp_to", cmp_to_log[0], 0);
    check("single_err", err, 0);
    wait_idle(50);

    // round-robin: all requesters valid straight out of reset
    do_reset(2);
    clear_logs();
    done_delay = 3; clr_lag = 1;
    for (int i = 0; i < N; i++) begin
      req_msg_addr[i*16 +: 16] = 16'h1000 + 16'(i);
      req_out_addr[i*16 +: 16] = 16'h2000 + 16'(i);
    end
    req_valid = '1;
    tick(20);
    req_valid = '0;
    wait_idle(300);
    check("rr_grant0", grant_log[0], 0);
    check("rr_grant1", grant_log[1], 1);
    check("rr_grant2", grant_log[2], 2);
    check("rr_grant3", grant_log[3], 3);
    check("rr_grant4", grant_log[4], 0);
    check("rr_grant5", grant_log[5], 1);

    // stale done: done still high from the last job, dropped 2 cycles after start
    clear_logs();
    done_delay = 8; clr_lag = 2;
    submit(1, 16'h3000, 16'h3100, t);
    wait_cmp(100, r1);
    check("stale_done_at_start", done_at_start_log[0], 1);
    check("stale_cmp_lat", r1 - start_log[0], 9);
    check("stale_cmp_to", cmp_to_log[0], 0);
    wait_idle(50);

    // timeout: core never finishes the first job; the queued job still runs
    clear_logs();
    done_delay = 0; clr_lag = 1;
    submit(1, 16'h4000, 16'h4100, t);
    submit(3, 16'h5000, 16'h5100, t);
    wait_cmp(100, r1);
    done_delay = 5;
    check("to_cmp_lat", r1 - start_log[0], TO);
    check("to_cmp_to", cmp_to_log[0], 1);
    check("to_cmp_id", cmp_id_log[0], 1);
    check("to_err", err, 1);
    wait_cmp(100, r2);
    check("to_next_gap", start_log[1] - r1, 2);
    check("to_next_msg", start_msg_log[1], 16'h5000);
    check("to_next_id", cmp_id_log[1], 3);
    check("to_next_to", cmp_to_log[1], 0);
    check("to_err_sticky", err, 1);
    wait_idle(50);

    // push and pop in the same cycle at count 1
    do_reset(2);
    clear_logs();
    done_delay = 10; clr_lag = 1;
    submit(0, 16'h6000, 16'h6100, t);
    submit(1, 16'h6001, 16'h6101, t);
    wait_cmp(100, r1);
    submit(2, 16'h6002, 16'h6102, t);
    check("pp_transfer_cycle", t, r1 + 1);
    check("pp_count", u_dut.u_fifo.count, 1);
    wait_cmp(100, r2);
    wait_cmp(100, r2);
    check("pp_order_id1", cmp_id_log[1], 1);
    check("pp_order_id2", cmp_id_log[2], 2);
    check("pp_order_msg2", start_msg_log[2], 16'h6002);
    wait_idle(50);

    // reset mid-job with two jobs queued
    clear_logs();
    done_delay = 60; clr_lag = 1;
    submit(0, 16'h7000, 16'h7100, t);
    submit(1, 16'h7001, 16'h7101, t);
    submit(2, 16'h7002, 16'h7102, t);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (u_dut.state_q == sha256_sched_pkg::WAIT_DONE && mq.size() == 2) begin
        ok = 1;
        break;
      end
    end
    check("mid_reach_wait_done", ok, 1);
    @(posedge clk);
    #1;
    cmp_log.delete();
    do_reset(3);
    tick(40);
    check("mid_no_cmp", cmp_log.size(), 0);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
